// File: rtl/swap_sequencer_if.sv
// Command/status bundle between swap_sequencer and its swap register file plus control host.
// master = sequencer side, slave = file/host side.
interface swap_sequencer_if #(
   parameter int unsigned N_REG = 8,
   parameter int unsigned W     = 4
);
   localparam int unsigned AW = $clog2(N_REG);
   localparam int unsigned CW = $clog2(N_REG * (N_REG - 1) / 2 + 1);

   logic                 start;
   logic [1:0]           op;
   logic                 init_first;
   logic [N_REG*W-1:0]   r_in;
   logic                 init;
   logic                 swap;
   logic [AW-1:0]        x;
   logic [AW-1:0]        y;
   logic                 busy;
   logic                 done;
   logic [CW-1:0]        swap_count;

   modport master (
      input  start, op, init_first, r_in,
      output init, swap, x, y, busy, done, swap_count
   );

   modport slave (
      output start, op, init_first, r_in,
      input  init, swap, x, y, busy, done, swap_count
   );
endinterface

// File: rtl/swap_sequencer.sv
// Drives a swap register file through init, full reversal or bubble sort from one start pulse.
// All outputs are registered; a swap issued in SWP is committed by the file on the same edge.
module swap_sequencer #(
   parameter int unsigned N_REG = 8,
   parameter int unsigned W     = 4
) (
   input logic               clk,
   input logic               rst_n,
   swap_sequencer_if.master  bus
);
   localparam int unsigned AW = $clog2(N_REG);
   localparam int unsigned CW = $clog2(N_REG * (N_REG - 1) / 2 + 1);

   localparam logic [AW-1:0] TOP_IDX   = AW'(N_REG - 1);
   localparam logic [AW-1:0] LAST_CMP  = AW'(N_REG - 2);
   localparam logic [AW-1:0] LAST_REV  = AW'(N_REG / 2 - 1);
   localparam logic [AW-1:0] LAST_PASS = AW'(N_REG - 2);
   localparam logic [CW-1:0] CNT_MAX   = '1;

   typedef enum logic [2:0] {
      S_IDLE, S_INIT, S_REV, S_CMP, S_SWP, S_DONE
   } state_t;

   state_t        state;
   logic [1:0]    op_q;
   logic          dirty;
   logic [AW-1:0] idx;
   logic [AW-1:0] pass;

   logic [W-1:0]  a_c;
   logic [W-1:0]  b_c;
   logic          ooo_c;
   logic          pass_over_c;
   logic [AW-1:0] ip1_c;
   logic [CW-1:0] cnt_inc_c;

   // Neighbour compare and end-of-pass decision for the current pointer
   always_comb begin
      ip1_c       = idx + AW'(1);
      a_c         = bus.r_in[32'(idx) * W +: W];
      b_c         = bus.r_in[32'(ip1_c) * W +: W];
      ooo_c       = (op_q == 2'd2) ? (a_c > b_c) : (a_c < b_c);
      pass_over_c = !dirty || (pass == LAST_PASS);
      cnt_inc_c   = (bus.swap_count == CNT_MAX) ? bus.swap_count : bus.swap_count + CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         op_q           <= 2'd0;
         dirty          <= 1'b0;
         idx            <= '0;
         pass           <= '0;
         bus.init       <= 1'b0;
         bus.swap       <= 1'b0;
         bus.x          <= '0;
         bus.y          <= '0;
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
         bus.swap_count <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  op_q           <= bus.op;
                  bus.busy       <= 1'b1;
                  bus.swap_count <= '0;
                  idx            <= '0;
                  pass           <= '0;
                  dirty          <= 1'b0;
                  if (bus.op == 2'd0 || bus.init_first) begin
                     state    <= S_INIT;
                     bus.init <= 1'b1;
                  end else if (bus.op == 2'd1) begin
                     state          <= S_REV;
                     bus.swap       <= 1'b1;
                     bus.x          <= '0;
                     bus.y          <= TOP_IDX;
                     bus.swap_count <= CW'(1);
                  end else begin
                     state <= S_CMP;
                  end
               end
            end

            S_INIT: begin
               bus.init <= 1'b0;
               if (op_q == 2'd0) begin
                  state    <= S_DONE;
                  bus.done <= 1'b1;
                  bus.busy <= 1'b0;
               end else if (op_q == 2'd1) begin
                  state          <= S_REV;
                  bus.swap       <= 1'b1;
                  bus.x          <= '0;
                  bus.y          <= TOP_IDX;
                  bus.swap_count <= cnt_inc_c;
               end else begin
                  state <= S_CMP;
               end
            end

            // Outputs already carry pair idx; advance to the next mirrored pair
            S_REV: begin
               if (idx == LAST_REV) begin
                  state    <= S_DONE;
                  bus.swap <= 1'b0;
                  bus.done <= 1'b1;
                  bus.busy <= 1'b0;
               end else begin
                  idx            <= ip1_c;
                  bus.x          <= ip1_c;
                  bus.y          <= TOP_IDX - ip1_c;
                  bus.swap_count <= cnt_inc_c;
               end
            end

            S_CMP: begin
               if (ooo_c) begin
                  state          <= S_SWP;
                  dirty          <= 1'b1;
                  bus.swap       <= 1'b1;
                  bus.x          <= idx;
                  bus.y          <= ip1_c;
                  bus.swap_count <= cnt_inc_c;
               end else if (idx != LAST_CMP) begin
                  idx <= ip1_c;
               end else if (pass_over_c) begin
                  state    <= S_DONE;
                  bus.done <= 1'b1;
                  bus.busy <= 1'b0;
               end else begin
                  idx   <= '0;
                  pass  <= pass + AW'(1);
                  dirty <= 1'b0;
               end
            end

            S_SWP: begin
               bus.swap <= 1'b0;
               state    <= S_CMP;
               if (idx != LAST_CMP) begin
                  idx <= ip1_c;
               end else if (pass_over_c) begin
                  state    <= S_DONE;
                  bus.done <= 1'b1;
                  bus.busy <= 1'b0;
               end else begin
                  idx   <= '0;
                  pass  <= pass + AW'(1);
                  dirty <= 1'b0;
               end
            end

            S_DONE: begin
               bus.done <= 1'b0;
               state    <= S_IDLE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_swap_sequencer.sv
// Bench for swap_sequencer: behavioural swap register file, table of whole operations,
// plus hand-written reset-mid-sort sequence.
module tb_swap_sequencer;
   localparam int unsigned N_REG = 8;
   localparam int unsigned W     = 4;

   typedef struct {
      logic [1:0]  op;
      logic        init_first;
      logic        do_load;
      logic [31:0] load;
      logic [31:0] exp_file;
      int          exp_swaps;
      int          exp_init;
      int          exp_lat;
      logic        extra_start;
   } vec_t;

   logic clk;
   logic rst_n;

   swap_sequencer_if #(.N_REG(N_REG), .W(W)) bus ();

   swap_sequencer #(.N_REG(N_REG), .W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural register file driven by the sequencer
   logic [W-1:0] rf [N_REG];
   logic         load_req;
   logic [31:0]  load_val;

   always @(posedge clk) begin
      if (load_req) begin
         for (int k = 0; k < N_REG; k++) rf[k] <= load_val[k*4 +: 4];
      end else if (bus.init) begin
         for (int k = 0; k < N_REG; k++) rf[k] <= 4'(k);
      end else if (bus.swap) begin
         rf[bus.x] <= rf[bus.y];
         rf[bus.y] <= rf[bus.x];
      end
   end

   always_comb begin
      for (int k = 0; k < N_REG; k++) bus.r_in[k*W +: W] = rf[k];
   end

   int n_chk;
   int n_fail;
   int n_swap;
   int n_init;
   int n_done;
   int viol;
   int xs[$];
   int ys[$];
   logic cur_sort;

   // Protocol monitor sampled mid-cycle
   always @(negedge clk) begin
      if (bus.swap) begin
         n_swap++;
         xs.push_back(int'(bus.x));
         ys.push_back(int'(bus.y));
         if (bus.x == bus.y) viol++;
         if (cur_sort && rf[bus.x] == rf[bus.y]) viol++;
      end
      if (bus.init) n_init++;
      if (bus.init && bus.swap) viol++;
      if (bus.done) n_done++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_mon();
      n_swap = 0;
      n_init = 0;
      n_done = 0;
      viol   = 0;
      xs.delete();
      ys.delete();
   endtask

   task automatic load_file(input logic [31:0] val);
      load_val = val;
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      int lat;
      if (v.do_load) load_file(v.load);
      clear_mon();
      cur_sort       = v.op[1];
      bus.op         = v.op;
      bus.init_first = v.init_first;
      bus.start      = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      lat       = 1;
      chk("busy_after_start", 32'(bus.busy), 32'd1);
      while (!bus.done && lat < 300) begin
         if (v.extra_start) begin
            bus.start = (lat == 10);
            bus.op    = 2'd0;
         end
         @(negedge clk);
         lat++;
      end
      bus.start = 1'b0;
      chk("latency", 32'(lat), 32'(v.exp_lat));
      chk("busy_at_done", 32'(bus.busy), 32'd0);
      chk("swap_count", 32'(bus.swap_count), 32'(v.exp_swaps));
      chk("swaps_seen", 32'(n_swap), 32'(v.exp_swaps));
      chk("inits_seen", 32'(n_init), 32'(v.exp_init));
      chk("file", bus.r_in, v.exp_file);
      if (v.op == 2'd1) begin
         for (int k = 0; k < 4; k++) begin
            chk("rev_x", 32'((k < xs.size()) ? xs[k] : -1), 32'(k));
            chk("rev_y", 32'((k < ys.size()) ? ys[k] : -1), 32'(7 - k));
         end
      end
      repeat (4) @(negedge clk);
      chk("done_pulses", 32'(n_done), 32'd1);
      chk("done_low_after", 32'(bus.done), 32'd0);
      chk("protocol_viol", 32'(viol), 32'd0);
   endtask

   vec_t vecs[6];

   initial begin
      int cyc;
      n_chk  = 0;
      n_fail = 0;
      clear_mon();
      cur_sort       = 1'b0;
      load_req       = 1'b0;
      load_val       = '0;
      rst_n          = 1'b0;
      bus.start      = 1'b0;
      bus.op         = 2'd0;
      bus.init_first = 1'b0;

      //           op    if    load  load_val      exp_file      sw  in lat extra
      vecs[0] = '{2'd0, 1'b0, 1'b0, 32'h0,        32'h76543210, 0,  1, 2,  1'b0};
      vecs[1] = '{2'd1, 1'b1, 1'b0, 32'h0,        32'h01234567, 4,  1, 6,  1'b0};
      vecs[2] = '{2'd2, 1'b0, 1'b1, 32'h01234567, 32'h76543210, 28, 0, 78, 1'b0};
      vecs[3] = '{2'd3, 1'b1, 1'b0, 32'h0,        32'h01234567, 28, 1, 79, 1'b0};
      vecs[4] = '{2'd3, 1'b0, 1'b0, 32'h0,        32'h01234567, 0,  0, 8,  1'b0};
      vecs[5] = '{2'd2, 1'b0, 1'b1, 32'h31200313, 32'h33321100, 12, 0, 41, 1'b1};

      repeat (2) @(negedge clk);
      chk("rst_init", 32'(bus.init), 32'd0);
      chk("rst_swap", 32'(bus.swap), 32'd0);
      chk("rst_x", 32'(bus.x), 32'd0);
      chk("rst_y", 32'(bus.y), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_swap_count", 32'(bus.swap_count), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int v = 0; v < 6; v++) run_vec(vecs[v]);

      // Reset asserted while the third swap of a sort is on the bus
      load_file(32'h01234567);
      clear_mon();
      cur_sort       = 1'b1;
      bus.op         = 2'd2;
      bus.init_first = 1'b0;
      bus.start      = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      cyc = 0;
      #1;
      while (n_swap < 3 && cyc < 100) begin
         @(negedge clk);
         #1;
         cyc++;
      end
      chk("mid_sort_third_swap", 32'(n_swap), 32'd3);
      chk("mid_sort_swap_high", 32'(bus.swap), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_swap", 32'(bus.swap), 32'd0);
      chk("async_rst_init", 32'(bus.init), 32'd0);
      chk("async_rst_busy", 32'(bus.busy), 32'd0);
      chk("async_rst_done", 32'(bus.done), 32'd0);
      chk("async_rst_count", 32'(bus.swap_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("post_rst_no_swaps", 32'(n_swap), 32'd3);
      chk("post_rst_no_done", 32'(n_done), 32'd0);
      chk("post_rst_idle_busy", 32'(bus.busy), 32'd0);
      chk("post_rst_count", 32'(bus.swap_count), 32'd0);

      // Sequencer must accept a fresh operation from IDLE after the reset
      run_vec(vecs[1]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
